// File: rtl/oled_spi_arbiter.sv
// Round-robin, burst-granular arbiter that feeds one SPI master from NREQ byte streams.
// The grant is held from the first byte of a burst to its last byte, or until an idle timeout releases it.
module oled_spi_arbiter #(
    parameter int NREQ        = 2,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     sclk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_dc,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          grant,
    output logic                     spi_start,
    output logic [DATA_W-1:0]        spi_data,
    output logic                     spi_dc,
    input  logic                     spi_busy,
    input  logic                     spi_done,
    output logic                     timeout_err
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_XFER
    } state_t;

    state_t              r_state;
    logic [NREQ-1:0]     r_grant;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_rr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_last;
    logic                r_spi_start;
    logic [DATA_W-1:0]   r_spi_data;
    logic                r_spi_dc;
    logic                r_timeout_err;

    logic                w_found;
    logic [IDX_W-1:0]    w_win;
    logic                w_sel_valid;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_dc;
    logic                w_sel_last;
    logic                w_accept;
    logic                w_own_open;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_rr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDX_W'((int'(r_rr) + k) % NREQ);
            end
        end
    end

    assign w_sel_valid = req_valid[r_owner];
    assign w_sel_data  = req_data[int'(r_owner) * DATA_W +: DATA_W];
    assign w_sel_dc    = req_dc[r_owner];
    assign w_sel_last  = req_last[r_owner];
    assign w_own_open  = (r_state == S_OWN) && !spi_busy;
    assign w_accept    = w_own_open && w_sel_valid;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = w_own_open && (r_owner == IDX_W'(gi));
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_owner       <= '0;
            r_rr          <= IDX_W'(NREQ - 1);
            r_cnt         <= '0;
            r_last        <= 1'b0;
            r_spi_start   <= 1'b0;
            r_spi_data    <= '0;
            r_spi_dc      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_spi_start   <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_owner <= w_win;
                        r_cnt   <= '0;
                        r_state <= S_OWN;
                    end else begin
                        r_grant <= '0;
                    end
                end
                S_OWN: begin
                    if (w_accept) begin
                        r_last      <= w_sel_last;
                        r_spi_data  <= w_sel_data;
                        r_spi_dc    <= w_sel_dc;
                        r_spi_start <= 1'b1;
                        r_state     <= S_XFER;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        // Stalled owner: drop the burst so others are not locked out.
                        r_grant       <= '0;
                        r_timeout_err <= 1'b1;
                        r_rr          <= r_owner;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (spi_done) begin
                        if (r_last) begin
                            r_grant <= '0;
                            r_rr    <= r_owner;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_OWN;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant       = r_grant;
    assign spi_start   = r_spi_start;
    assign spi_data    = r_spi_data;
    assign spi_dc      = r_spi_dc;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Bench for oled_spi_arbiter: directed scenarios plus random bursts, checked by a
// burst-level round-robin reference model and per-requester expected-byte queues.
module tb_oled_spi_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int TO   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid, req_dc, req_last, req_ready, grant;
    logic [NREQ*DW-1:0] req_data;
    logic               spi_start, spi_dc, spi_busy, spi_done, timeout_err;
    logic [DW-1:0]      spi_data;
    logic               sl_busy, force_busy;

    assign spi_busy = sl_busy | force_busy;

    always #5 clk = ~clk;

    oled_spi_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .sclk(clk), .reset(rst),
        .req_valid(req_valid), .req_data(req_data), .req_dc(req_dc), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .spi_start(spi_start), .spi_data(spi_data), .spi_dc(spi_dc),
        .spi_busy(spi_busy), .spi_done(spi_done), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
        logic       last;
    } byte_t;

    byte_t rq[NREQ][$];
    byte_t exp_q[NREQ][$];
    int    start_log[$];
    int    n_vec = 0;
    int    n_err = 0;
    bit    mon_en = 1'b0;
    bit    rand_lat = 1'b0;
    logic [NREQ-1:0] acc;

    int    m_rr, m_owner, w;
    bit    m_idle, m_last, m_inflight, rel;
    logic [7:0] m_data;
    logic  m_dc;
    byte_t e;
    int    sl_cnt = 0;
    int    exp_t2[8] = '{1, 1, 1, 2, 2, 2, 1, 2};
    int    exp_t3[5] = '{1, 1, 1, 2, 2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int model_winner(input logic [NREQ-1:0] v, input int rr);
        for (int k = 1; k <= NREQ; k++)
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        return -1;
    endfunction

    task automatic push_byte(input int i, input logic [7:0] d, input logic dc, input logic last);
        byte_t b;
        b = '{data: d, dc: dc, last: last};
        rq[i].push_back(b);
        exp_q[i].push_back(b);
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NREQ; i++) begin
            rq[i].delete();
            exp_q[i].delete();
        end
    endtask

    task automatic mon_sync(input int rr);
        m_rr = rr;
        m_idle = 1'b1;
        m_inflight = 1'b0;
        for (int i = 0; i < NREQ; i++) exp_q[i].delete();
        start_log.delete();
        mon_en = 1'b1;
    endtask

    // which: 0 waits for spi_start, 1 waits for spi_done; returns at posedge+1
    task automatic wait_sig(input string name, input int which, input int maxc);
        int c;
        bit seen;
        c = 0;
        seen = 1'b0;
        while (!seen && c < maxc) begin
            @(posedge clk); #1;
            c++;
            seen = (which == 0) ? spi_start : spi_done;
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL %s: event not seen within %0d cycles", name, maxc);
        end
    endtask

    task automatic drain(input string name, input int maxc);
        int c;
        c = 0;
        while (!(rq[0].size() == 0 && rq[1].size() == 0 && grant == '0 && !spi_busy) && c < maxc) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= maxc) begin
            n_vec++; n_err++;
            $display("FAIL %s: traffic did not drain in %0d cycles (grant=%b)", name, maxc, grant);
        end
        @(posedge clk); #1;
        if (mon_en) check({name, "_exp_empty"}, exp_q[0].size() + exp_q[1].size(), 0);
    endtask

    // Requester drivers: present queue heads, retire a byte after each handshake.
    initial begin
        req_valid = '0; req_data = '0; req_dc = '0; req_last = '0; acc = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                byte_t b;
                if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    b = rq[i][0];
                    req_valid[i] = 1'b1;
                    req_data[i*DW +: DW] = b.data;
                    req_dc[i] = b.dc;
                    req_last[i] = b.last;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            #1 acc = req_valid & req_ready;
        end
    end

    // SPI master stand-in: busy for a few cycles after each start, then a done pulse.
    initial begin
        sl_busy = 1'b0; spi_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sl_busy = 1'b0; spi_done = 1'b0; sl_cnt = 0;
            end else begin
                spi_done = 1'b0;
                if (sl_cnt > 0) begin
                    sl_cnt--;
                    if (sl_cnt == 0) begin
                        sl_busy = 1'b0;
                        spi_done = 1'b1;
                    end
                end
                if (spi_start) begin
                    sl_busy = 1'b1;
                    sl_cnt = rand_lat ? int'($urandom_range(4, 1)) : 2;
                end
            end
        end
    end

    // Monitor: burst-level round-robin model and per-requester byte scoreboard.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (mon_en) begin
                rel = 1'b0;
                if (spi_done && m_inflight) begin
                    check("hold_data", spi_data, m_data);
                    check("hold_dc", spi_dc, m_dc);
                    m_inflight = 1'b0;
                    if (m_last) begin
                        check("release_grant", grant, 0);
                        m_rr = m_owner;
                        m_idle = 1'b1;
                        rel = 1'b1;
                    end
                end
                if (!rel) begin
                    if (m_idle) begin
                        if (req_valid != '0) begin
                            w = model_winner(req_valid, m_rr);
                            check("arb_grant", grant, 1 << w);
                            m_owner = w;
                            m_idle = 1'b0;
                        end else begin
                            check("idle_grant", grant, 0);
                        end
                    end else begin
                        check("burst_grant", grant, 1 << m_owner);
                    end
                end
                check("no_timeout", timeout_err, 0);
                if (spi_start) begin
                    if (m_idle || exp_q[m_owner].size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_start: data=%0h grant=%b", spi_data, grant);
                    end else begin
                        e = exp_q[m_owner].pop_front();
                        check("spi_data", spi_data, e.data);
                        check("spi_dc", spi_dc, e.dc);
                        m_last = e.last;
                        m_data = e.data;
                        m_dc = e.dc;
                        m_inflight = 1'b1;
                        start_log.push_back(int'(grant));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, r;
        rst = 1'b1;
        force_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_ready", req_ready, 0);
        check("rst_start", spi_start, 0);
        check("rst_data", spi_data, 0);
        check("rst_dc", spi_dc, 0);
        check("rst_timeout", timeout_err, 0);
        rst = 1'b0;
        mon_sync(NREQ - 1);

        // T1: single command byte, latency and release
        push_byte(0, 8'hAE, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("t1_grant", grant, 1);
        @(posedge clk); #1;
        check("t1_start", spi_start, 1);
        check("t1_data", spi_data, 8'hAE);
        check("t1_dc", spi_dc, 0);
        wait_sig("t1_done", 1, 20);
        check("t1_release", grant, 0);
        drain("t1", 50);

        // T2: simultaneous 3-byte bursts from reset, then a fresh contest
        mon_en = 1'b0;
        rst = 1'b1;
        clear_queues();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_sync(NREQ - 1);
        for (int j = 0; j < 3; j++) begin
            push_byte(0, 8'h40 + 8'(j), 1'b1, j == 2);
            push_byte(1, 8'h80 + 8'(j), 1'b1, j == 2);
        end
        drain("t2a", 300);
        push_byte(0, 8'h4F, 1'b0, 1'b1);
        push_byte(1, 8'h8F, 1'b0, 1'b1);
        drain("t2b", 200);
        check("t2_count", start_log.size(), 8);
        for (int k = 0; k < 8 && k < start_log.size(); k++) check("t2_order", start_log[k], exp_t2[k]);

        // T3: req1 arrives mid-burst and must wait for req0's last byte
        start_log.delete();
        push_byte(0, 8'h20, 1'b1, 1'b0);
        push_byte(0, 8'h21, 1'b1, 1'b0);
        push_byte(0, 8'h22, 1'b1, 1'b1);
        wait_sig("t3_first", 0, 20);
        push_byte(1, 8'h30, 1'b1, 1'b0);
        push_byte(1, 8'h31, 1'b1, 1'b1);
        drain("t3", 300);
        check("t3_count", start_log.size(), 5);
        for (int k = 0; k < 5 && k < start_log.size(); k++) check("t3_order", start_log[k], exp_t3[k]);

        // T4: stalled burst is released by the idle timeout
        mon_en = 1'b0;
        push_byte(0, 8'h55, 1'b0, 1'b0);
        wait_sig("t4_done", 1, 30);
        push_byte(1, 8'h66, 1'b1, 1'b1);
        for (int k = 1; k < TO; k++) begin
            @(posedge clk); #1;
            check("t4_hold_grant", grant, 1);
            check("t4_no_err", timeout_err, 0);
        end
        @(posedge clk); #1;
        check("t4_release", grant, 0);
        check("t4_err_pulse", timeout_err, 1);
        @(posedge clk); #1;
        check("t4_err_end", timeout_err, 0);
        check("t4_next_grant", grant, 2);
        drain("t4", 100);

        // T5: busy master blocks acceptance; release lets the byte in the same cycle
        mon_sync(1);
        force_busy = 1'b1;
        push_byte(0, 8'h5A, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("t5_grant", grant, 1);
        repeat (4) begin
            @(posedge clk); #1;
            check("t5_ready_low", req_ready, 0);
            check("t5_no_start", spi_start, 0);
        end
        force_busy = 1'b0;
        #1 check("t5_ready_high", req_ready, 1);
        @(posedge clk); #1;
        check("t5_start", spi_start, 1);
        check("t5_data", spi_data, 8'h5A);
        drain("t5", 50);

        // T6: reset during a transfer drops everything immediately
        push_byte(0, 8'h10, 1'b0, 1'b0);
        push_byte(0, 8'h11, 1'b0, 1'b0);
        push_byte(0, 8'h12, 1'b0, 1'b1);
        wait_sig("t6_start", 0, 20);
        mon_en = 1'b0;
        #1 rst = 1'b1;
        clear_queues();
        #1;
        check("t6_grant", grant, 0);
        check("t6_start", spi_start, 0);
        check("t6_timeout", timeout_err, 0);
        check("t6_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_sync(NREQ - 1);
        push_byte(0, 8'hC0, 1'b0, 1'b1);
        push_byte(1, 8'hC1, 1'b1, 1'b1);
        drain("t6", 100);
        check("t6_count", start_log.size(), 2);
        if (start_log.size() > 0) check("t6_first_owner", start_log[0], 1);

        // Random bursts with random master latency
        rand_lat = 1'b1;
        repeat (40) begin
            r = int'($urandom_range(NREQ - 1, 0));
            len = int'($urandom_range(4, 1));
            for (int j = 0; j < len; j++)
                push_byte(r, 8'($urandom), 1'($urandom), j == len - 1);
            repeat ($urandom_range(8, 0)) @(posedge clk);
            #1;
        end
        drain("rand", 4000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
